// File: rtl/round_pipe.sv
// ============================================================================
// Module   : round_pipe
// Purpose  : Two-stage rounding pipeline with renormalisation and inexact count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module round_pipe #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_mode,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [MANT_W:0]    in_mant,
  input  logic               in_guard,
  input  logic               in_sticky,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MANT_W:0]    out_mant,
  output logic               out_inexact,
  output logic               out_ovf,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt_inexact
);

  localparam logic [EXP_W-1:0]  c_exp_one = EXP_W'(1);
  localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_cnt_max = '1;
  localparam logic [MANT_W+1:0] c_sum_zero = '0;

  logic               r_v1;
  logic               r_sign1;
  logic [EXP_W-1:0]   r_exp1;
  logic [MANT_W:0]    r_mant1;
  logic               r_inex1;
  logic               r_inc1;

  logic               w_en1;
  logic               w_en2;
  logic               w_inexact;
  logic               w_inc;
  logic [MANT_W+1:0]  w_sum;
  logic               w_carry;
  logic [MANT_W:0]    w_mant2;
  logic [EXP_W-1:0]   w_exp2;
  logic               w_ovf2;

  assign w_en2    = ~out_valid | out_ready;
  assign w_en1    = ~r_v1 | w_en2;
  assign in_ready = w_en1;

  assign w_inexact = in_guard | in_sticky;

  // Modes 6 and 7 fall through to round-to-nearest-even.
  always_comb begin
    w_inc = 1'b0;
    case (in_mode)
      3'd1:    w_inc = 1'b0;
      3'd2:    w_inc = ~in_sign & w_inexact;
      3'd3:    w_inc = in_sign & w_inexact;
      3'd4:    w_inc = in_sign ? (in_guard & in_sticky) : in_guard;
      3'd5:    w_inc = w_inexact;
      default: w_inc = in_guard & (in_sticky | in_mant[0]);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1    <= 1'b0;
      r_sign1 <= 1'b0;
      r_exp1  <= '0;
      r_mant1 <= '0;
      r_inex1 <= 1'b0;
      r_inc1  <= 1'b0;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_sign1 <= in_sign;
        r_exp1  <= in_exp;
        r_mant1 <= in_mant;
        r_inex1 <= w_inexact;
        r_inc1  <= w_inc;
      end
    end
  end

  // A carry-out only happens from all-ones, so the shifted sum is 1 followed by zeros.
  assign w_sum   = {1'b0, r_mant1} + {c_sum_zero[MANT_W+1:1], r_inc1};
  assign w_carry = w_sum[MANT_W+1];
  assign w_mant2 = w_carry ? w_sum[MANT_W+1:1] : w_sum[MANT_W:0];
  assign w_exp2  = w_carry ? (r_exp1 + c_exp_one) : r_exp1;
  assign w_ovf2  = w_carry & (&r_exp1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_mant    <= '0;
      out_inexact <= 1'b0;
      out_ovf     <= 1'b0;
    end else if (w_en2) begin
      out_valid <= r_v1;
      if (r_v1) begin
        out_sign    <= r_sign1;
        out_exp     <= w_exp2;
        out_mant    <= w_mant2;
        out_inexact <= r_inex1;
        out_ovf     <= w_ovf2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_inexact <= '0;
    end else if (cnt_clr) begin
      cnt_inexact <= '0;
    end else if (out_valid && out_ready && out_inexact && (cnt_inexact != c_cnt_max)) begin
      cnt_inexact <= cnt_inexact + c_cnt_one;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_round_pipe.sv
// ============================================================================
// Module   : tb_round_pipe
// Purpose  : Scoreboard bench for round_pipe with directed rounding vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_round_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_mode = '0;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic        in_guard = 1'b0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_inexact;
  logic        out_ovf;
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt_inexact;

  logic        in_ready2, out_valid2, out_sign2, out_inexact2, out_ovf2;
  logic [9:0]  out_exp2;
  logic [23:0] out_mant2;
  logic [1:0]  cnt_inexact2;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic        inex;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  round_pipe #(.MANT_W(23), .EXP_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_guard(in_guard), .in_sticky(in_sticky), .out_valid(out_valid),
    .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_mant(out_mant), .out_inexact(out_inexact), .out_ovf(out_ovf),
    .cnt_clr(cnt_clr), .cnt_inexact(cnt_inexact)
  );

  // Narrow-counter instance shares stimulus to exercise saturation.
  round_pipe #(.MANT_W(23), .EXP_W(10), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_mode(in_mode), .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_guard(in_guard), .in_sticky(in_sticky), .out_valid(out_valid2),
    .out_ready(out_ready), .out_sign(out_sign2), .out_exp(out_exp2),
    .out_mant(out_mant2), .out_inexact(out_inexact2), .out_ovf(out_ovf2),
    .cnt_clr(cnt_clr), .cnt_inexact(cnt_inexact2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got mant 0x%0h, expected no output", out_mant);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_sign", {31'd0, out_sign}, {31'd0, e.sign});
        check("out_exp", {22'd0, out_exp}, {22'd0, e.exp});
        check("out_mant", {8'd0, out_mant}, {8'd0, e.mant});
        check("out_inexact", {31'd0, out_inexact}, {31'd0, e.inex});
        check("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
      end
    end
  end

  task automatic send(input logic [2:0] m, input logic sg, input logic [9:0] e,
                      input logic [23:0] mt, input logic g, input logic s,
                      input logic [9:0] xe, input logic [23:0] xm,
                      input logic xi, input logic xo);
    bit ok = 0;
    in_mode = m; in_sign = sg; in_exp = e; in_mant = mt;
    in_guard = g; in_sticky = s; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0, expected 1 within 20 cycles");
    end else begin
      sb.push_back('{sg, xe, xm, xi, xo});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_cnt", {16'd0, cnt_inexact}, 32'd0);
    check("rst_out_mant", {8'd0, out_mant}, 32'd0);
    check("rst_out_exp", {22'd0, out_exp}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Tie-to-even with latency check on an empty pipe.
    send(3'd0, 1'b0, 10'h07F, 24'h800000, 1'b1, 1'b0, 10'h07F, 24'h800000, 1'b1, 1'b0);
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_two", {31'd0, out_valid}, 32'd1);
    drain();
    send(3'd0, 1'b0, 10'h07F, 24'h800001, 1'b1, 1'b0, 10'h07F, 24'h800002, 1'b1, 1'b0);
    send(3'd0, 1'b0, 10'h080, 24'hFFFFFF, 1'b1, 1'b1, 10'h081, 24'h800000, 1'b1, 1'b0);
    send(3'd0, 1'b1, 10'h3FF, 24'hFFFFFF, 1'b1, 1'b1, 10'h000, 24'h800000, 1'b1, 1'b1);
    // Mode sweep on mant 0x800001, guard 0, sticky 1.
    send(3'd2, 1'b0, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800002, 1'b1, 1'b0);
    send(3'd2, 1'b1, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0);
    send(3'd3, 1'b0, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0);
    send(3'd3, 1'b1, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800002, 1'b1, 1'b0);
    send(3'd5, 1'b0, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800002, 1'b1, 1'b0);
    send(3'd5, 1'b1, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800002, 1'b1, 1'b0);
    send(3'd1, 1'b0, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0);
    send(3'd1, 1'b1, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0);
    send(3'd4, 1'b0, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0);
    send(3'd4, 1'b1, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0);
    send(3'd4, 1'b0, 10'h010, 24'h800001, 1'b1, 1'b0, 10'h010, 24'h800002, 1'b1, 1'b0);
    send(3'd4, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0, 10'h010, 24'h800001, 1'b1, 1'b0);
    send(3'd7, 1'b0, 10'h010, 24'h800001, 1'b0, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0);
    send(3'd7, 1'b1, 10'h010, 24'h800001, 1'b1, 1'b0, 10'h010, 24'h800002, 1'b1, 1'b0);
    send(3'd5, 1'b0, 10'h010, 24'h800001, 1'b0, 1'b0, 10'h010, 24'h800001, 1'b0, 1'b0);
    drain();
    // 18 inexact items so far; the exact one leaves the count alone.
    check("cnt_after_sweep", {16'd0, cnt_inexact}, 32'd18);
    check("cnt2_saturated", {30'd0, cnt_inexact2}, 32'd3);

    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("cnt_clr_idle", {16'd0, cnt_inexact}, 32'd0);
    check("cnt2_clr_idle", {30'd0, cnt_inexact2}, 32'd0);
    for (int i = 0; i < 5; i++)
      send(3'd0, 1'b0, 10'h020, 24'h800001, 1'b1, 1'b1, 10'h020, 24'h800002, 1'b1, 1'b0);
    drain();
    check("cnt_five", {16'd0, cnt_inexact}, 32'd5);
    check("cnt2_sat_five", {30'd0, cnt_inexact2}, 32'd3);
    send(3'd5, 1'b1, 10'h020, 24'h812345, 1'b0, 1'b0, 10'h020, 24'h812345, 1'b0, 1'b0);
    drain();
    check("cnt_exact_hold", {16'd0, cnt_inexact}, 32'd5);

    cnt_clr = 1'b1;
    send(3'd5, 1'b0, 10'h020, 24'h800001, 1'b0, 1'b1, 10'h020, 24'h800002, 1'b1, 1'b0);
    drain();
    cnt_clr = 1'b0;
    check("cnt_clr_handshake", {16'd0, cnt_inexact}, 32'd0);

    // Backpressure: two accepts fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    send(3'd0, 1'b0, 10'h040, 24'hA00000, 1'b0, 1'b0, 10'h040, 24'hA00000, 1'b0, 1'b0);
    send(3'd0, 1'b0, 10'h041, 24'hB00001, 1'b1, 1'b1, 10'h041, 24'hB00002, 1'b1, 1'b0);
    in_mant = 24'hC00003; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_mant", {8'd0, out_mant}, 32'h00A00000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      begin
        send(3'd0, 1'b0, 10'h042, 24'hC00003, 1'b1, 1'b0, 10'h042, 24'hC00004, 1'b1, 1'b0);
        send(3'd0, 1'b1, 10'h043, 24'hD00004, 1'b1, 1'b0, 10'h043, 24'hD00004, 1'b1, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("drain_no_gap", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    drain();
    check("cnt_after_bp", {16'd0, cnt_inexact}, 32'd3);

    // Reset while two items are in flight.
    send(3'd0, 1'b0, 10'h050, 24'h800001, 1'b1, 1'b1, 10'h050, 24'h800002, 1'b1, 1'b0);
    send(3'd0, 1'b0, 10'h051, 24'h800001, 1'b1, 1'b1, 10'h051, 24'h800002, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_cnt", {16'd0, cnt_inexact}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    send(3'd2, 1'b0, 10'h060, 24'h8ABCDE, 1'b1, 1'b0, 10'h060, 24'h8ABCDF, 1'b1, 1'b0);
    check("rel_lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("rel_lat_two", {31'd0, out_valid}, 32'd1);
    drain();
    check("rel_cnt", {16'd0, cnt_inexact}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected end before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
